// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Four-state execute controller (IDLE/READ/EXEC/WB) that sits in
//            front of an 8-bit ALU and owns the 8x8 register file and flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int NREGS = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ld_valid_i,
    input  logic [2:0]  ld_addr_i,
    input  logic [7:0]  ld_data_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [15:0] instr_i,
    output logic [7:0]  alu_in1_o,
    output logic [7:0]  alu_in2_o,
    output logic [2:0]  alu_im_o,
    output logic [4:0]  alu_op_o,
    input  logic [7:0]  alu_res_i,
    input  logic        alu_cf_i,
    input  logic        alu_zf_i,
    input  logic        alu_sf_i,
    input  logic        alu_of_i,
    output logic [3:0]  flags_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic        show_valid_o,
    output logic [7:0]  show_data_o
);

    localparam logic [4:0] C_OP_NOP   = 5'b00000;
    localparam logic [4:0] C_OP_MOV   = 5'b00110;
    localparam logic [4:0] C_OP_NOT   = 5'b01000;
    localparam logic [4:0] C_OP_LAST  = 5'b01110;
    localparam logic [4:0] C_OP_SHOWR = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  regs_q [NREGS];
    logic [4:0]  op_q;
    logic [2:0]  rd_q, rs_q, im_q;
    logic [7:0]  a_q, b_q, res_q;
    logic [3:0]  cap_flags_q;
    logic [3:0]  flags_q;
    logic [7:0]  show_data_q;

    logic        w_legal, w_write, w_set_flags, w_is_show;
    logic        w_exec, w_wb;
    logic        unused_rsvd;

    assign unused_rsvd = ^instr_i[4:3];

    // Opcodes 00000..01110 and SHOWR are defined; everything else is illegal.
    assign w_legal     = (op_q <= C_OP_LAST) || (op_q == C_OP_SHOWR);
    assign w_is_show   = (op_q == C_OP_SHOWR);
    assign w_write     = (op_q != C_OP_NOP) && (op_q <= C_OP_LAST);
    assign w_set_flags = w_write && (op_q != C_OP_MOV) && (op_q != C_OP_NOT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!ld_valid_i && instr_valid_i) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses and the ALU drive are gated by reset so they stay low in the reset cycle.
    assign w_exec        = (state_q == ST_EXEC) && !reset_i;
    assign w_wb          = (state_q == ST_WB) && !reset_i;
    assign instr_ready_o = (state_q == ST_IDLE) && !ld_valid_i && !reset_i;
    assign alu_in1_o     = w_exec ? a_q  : 8'd0;
    assign alu_in2_o     = w_exec ? b_q  : 8'd0;
    assign alu_im_o      = w_exec ? im_q : 3'd0;
    assign alu_op_o      = w_exec ? op_q : C_OP_NOP;
    assign done_o        = w_wb;
    assign illegal_o     = w_wb && !w_legal;
    assign show_valid_o  = w_wb && w_is_show;
    assign show_data_o   = show_valid_o ? res_q : show_data_q;
    assign flags_o       = flags_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
            op_q        <= C_OP_NOP;
            rd_q        <= 3'd0;
            rs_q        <= 3'd0;
            im_q        <= 3'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            res_q       <= 8'd0;
            cap_flags_q <= 4'd0;
            flags_q     <= 4'd0;
            show_data_q <= 8'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (ld_valid_i) begin
                        regs_q[ld_addr_i] <= ld_data_i;
                    end else if (instr_valid_i) begin
                        op_q <= instr_i[15:11];
                        rd_q <= instr_i[10:8];
                        rs_q <= instr_i[7:5];
                        im_q <= instr_i[2:0];
                    end
                end
                ST_READ: begin
                    a_q <= regs_q[rd_q];
                    b_q <= regs_q[rs_q];
                end
                ST_EXEC: begin
                    res_q       <= alu_res_i;
                    cap_flags_q <= {alu_cf_i, alu_zf_i, alu_sf_i, alu_of_i};
                end
                ST_WB: begin
                    if (w_write)     regs_q[rd_q] <= res_q;
                    if (w_set_flags) flags_q      <= cap_flags_q;
                    if (w_is_show)   show_data_q  <= res_q;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed plus random bench for alu_sequencer with a stand-in ALU
//            and an architectural reference model of registers and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_in1, alu_in2, alu_res;
    logic [2:0]  alu_im;
    logic [4:0]  alu_op;
    logic        alu_cf, alu_zf, alu_sf, alu_of;
    logic [3:0]  flags;
    logic        done, illegal, show_valid;
    logic [7:0]  show_data;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_r [8];
    logic [3:0] m_flags;
    logic [7:0] m_show;

    always #5 clk = ~clk;

    alu_sequencer #(.NREGS(8)) dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .ld_valid_i    (ld_valid),
        .ld_addr_i     (ld_addr),
        .ld_data_i     (ld_data),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .alu_in1_o     (alu_in1),
        .alu_in2_o     (alu_in2),
        .alu_im_o      (alu_im),
        .alu_op_o      (alu_op),
        .alu_res_i     (alu_res),
        .alu_cf_i      (alu_cf),
        .alu_zf_i      (alu_zf),
        .alu_sf_i      (alu_sf),
        .alu_of_i      (alu_of),
        .flags_o       (flags),
        .done_o        (done),
        .illegal_o     (illegal),
        .show_valid_o  (show_valid),
        .show_data_o   (show_data)
    );

    // Stand-in ALU: returns {CF,ZF,SF,OF,result}.
    function automatic logic [11:0] alu_f(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] im);
        logic [8:0]  w;
        logic [7:0]  r;
        logic [15:0] dd;
        logic        c, o;
        w = 9'd0; r = 8'd0; c = 1'b0; o = 1'b0; dd = {a, a};
        case (op)
            5'd1:  begin w = {1'b0, a} + {1'b0, b};        r = w[7:0]; c = w[8];
                         o = (a[7] == b[7]) && (r[7] != a[7]); end
            5'd3:  begin w = {1'b0, a} - {1'b0, b};        r = w[7:0]; c = w[8];
                         o = (a[7] != b[7]) && (r[7] != a[7]); end
            5'd7:  begin w = {1'b0, a} + {1'b0, b} + 9'd1; r = w[7:0]; c = w[8];
                         o = (a[7] == b[7]) && (r[7] != a[7]); end
            5'd2:  r = a & b;
            5'd4:  r = a | b;
            5'd5:  r = a ^ b;
            5'd6:  r = b;
            5'd8:  r = ~a;
            5'd9:  r = 8'($signed(a) >>> im);
            5'd10: r = a >> im;
            5'd11, 5'd12: r = a << im;
            5'd13: begin dd = dd << im; r = dd[15:8]; end
            5'd14: begin dd = dd >> im; r = dd[7:0]; end
            5'd31: r = a;
            default: r = a ^ b;
        endcase
        return {c, (r == 8'd0), r[7], o, r};
    endfunction

    always_comb {alu_cf, alu_zf, alu_sf, alu_of, alu_res} = alu_f(alu_op, alu_in1, alu_in2, alu_im);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        #1 chk("ready_during_load", instr_ready, 1'b0);
        tick();
        ld_valid = 1'b0;
        m_r[a] = d;
    endtask

    task automatic junk_load(input bit noise);
        ld_valid = noise && ($urandom_range(0, 1) == 1);
        ld_addr  = 3'($urandom);
        ld_data  = 8'($urandom);
    endtask

    task automatic run_instr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [2:0] im, input bit noise);
        logic [11:0] e;
        logic        legal, wr, setf;
        instr_valid = 1'b1;
        instr = {op, rd, rs, 2'($urandom), im};
        ld_valid = 1'b0;
        #1 chk("ready_idle", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0; instr = 16'($urandom); junk_load(noise);
        #1;
        chk("ready_read", instr_ready, 1'b0);
        chk("aluop_read", alu_op, 5'd0);
        chk("done_read", done, 1'b0);
        tick(); junk_load(noise); #1;
        e = alu_f(op, m_r[rd], m_r[rs], im);
        chk("aluop_exec", alu_op, op);
        chk("in1_exec", alu_in1, m_r[rd]);
        chk("in2_exec", alu_in2, m_r[rs]);
        chk("im_exec", alu_im, im);
        chk("ready_exec", instr_ready, 1'b0);
        tick(); junk_load(noise); #1;
        legal = (op <= 5'd14) || (op == 5'd31);
        wr    = op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                           5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        setf  = wr && !(op inside {5'd6, 5'd8});
        chk("done_wb", done, 1'b1);
        chk("illegal_wb", illegal, !legal);
        chk("show_valid_wb", show_valid, op == 5'd31);
        chk("ready_wb", instr_ready, 1'b0);
        if (op == 5'd31) chk("show_data_wb", show_data, e[7:0]);
        if (wr)          m_r[rd] = e[7:0];
        if (setf)        m_flags = e[11:8];
        if (op == 5'd31) m_show  = e[7:0];
        tick(); ld_valid = 1'b0; #1;
        chk("done_after", done, 1'b0);
        chk("illegal_after", illegal, 1'b0);
        chk("flags", flags, m_flags);
        chk("show_data_hold", show_data, m_show);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
        m_flags = 4'd0;
        m_show  = 8'd0;
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 8'd0;
        instr_valid = 1'b0; instr = 16'd0;
        clear_model();
        tick(); tick(); tick();
        chk("rst_ready", instr_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_aluop", alu_op, 5'd0);
        chk("rst_flags", flags, 4'd0);
        chk("rst_show", show_data, 8'd0);
        reset = 1'b0;
        #1 chk("ready_after_rst", instr_ready, 1'b1);

        // ADD overflow into the sign bit
        load(3'd1, 8'h7F); load(3'd2, 8'h01);
        run_instr(5'd1, 3'd1, 3'd2, 3'd0, 1'b0);
        chk("add_flags", flags, 4'b0011);

        load(3'd3, 8'h05);
        run_instr(5'd3, 3'd3, 3'd3, 3'd0, 1'b0);
        chk("sub_zero_flags", flags[2], 1'b1);

        load(3'd6, 8'hC0);
        run_instr(5'd1, 3'd6, 3'd6, 3'd0, 1'b0);
        chk("flags_1010", flags, 4'b1010);
        run_instr(5'd6, 3'd4, 3'd3, 3'd0, 1'b0);
        run_instr(5'd8, 3'd5, 3'd0, 3'd0, 1'b0);
        chk("flags_kept", flags, 4'b1010);

        load(3'd1, 8'hA5);
        run_instr(5'd31, 3'd1, 3'd0, 3'd0, 1'b0);
        chk("showr_a5", show_data, 8'hA5);

        run_instr(5'd21, 3'd2, 3'd1, 3'd0, 1'b0);

        // Load and instruction offered together: load wins, instruction follows
        instr_valid = 1'b1; instr = {5'd1, 3'd7, 3'd7, 5'd0};
        load(3'd7, 8'h3C);
        run_instr(5'd1, 3'd7, 3'd7, 3'd0, 1'b0);
        run_instr(5'd31, 3'd7, 3'd0, 3'd0, 1'b0);
        chk("collision_sum", show_data, 8'h78);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 3)
                load(3'($urandom), 8'($urandom));
            else
                run_instr(($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 14)),
                          3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
        end

        // Reset during EXEC discards the instruction
        load(3'd1, 8'h11); load(3'd2, 8'h22);
        instr_valid = 1'b1; instr = {5'd1, 3'd1, 3'd2, 5'd0};
        tick(); instr_valid = 1'b0;
        tick();
        chk("mid_exec_op", alu_op, 5'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_aluop", alu_op, 5'd0);
        chk("mid_rst_ready", instr_ready, 1'b0);
        tick();
        chk("mid_rst_done", done, 1'b0);
        reset = 1'b0;
        clear_model();
        #1 chk("mid_rst_ready_after", instr_ready, 1'b1);
        chk("mid_rst_flags", flags, 4'd0);
        run_instr(5'd31, 3'd1, 3'd2, 3'd0, 1'b0);
        chk("mid_rst_r1", show_data, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execute controller that sits in front of the 8-bit ALU and drives it as the initiator side of its operand/opcode interface. Accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 8×8 register file, and holds ALU inputs stable for one full execute cycle. Captures result and flags, then writes back. Owns the architectural flag register (CF/ZF/SF/OF) and the SHOWR debug output.

## Interface
Parameters:
- NREGS, 8, register-file depth (address width 3; fixed by instruction format)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ld_valid  in  1  host register-load strobe
- ld_addr  in  3  load target register
- ld_data  in  8  load value
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer accepts instruction this cycle
- instr  in  16  [15:11] op, [10:8] rd, [7:5] rs, [4:3] reserved (ignored), [2:0] im
- alu_in1 / alu_in2  out  8 each  operand A = R[rd], B = R[rs]
- alu_im  out  3  shift/rotate amount
- alu_op  out  5  opcode to ALU
- alu_res  in  8  ALU result
- alu_cf / alu_zf / alu_sf / alu_of  in  1 each  ALU flags
- flags  out  4  architectural {CF,ZF,SF,OF}
- done  out  1  one-cycle pulse in WB
- illegal  out  1  one-cycle pulse in WB for unsupported opcode
- show_valid  out  1  one-cycle pulse in WB for SHOWR
- show_data  out  8  SHOWR value, held until next SHOWR

## Operation
- States: IDLE → READ → EXEC → WB → IDLE.
- IDLE: instr_ready = !ld_valid. ld_valid in IDLE writes R[ld_addr] = ld_data at the edge and has priority over instr_valid. On instr_valid & instr_ready, latch instr; go to READ. ld_valid outside IDLE is ignored.
- READ: latch R[rd] → A, R[rs] → B, im; go to EXEC.
- EXEC: drive alu_in1 = A, alu_in2 = B, alu_im = im, alu_op = op. At the closing edge, capture alu_res and the four ALU flags into internal registers; go to WB.
- Outside EXEC: alu_op = 5'b00000 (NOP); alu_in1/in2/im = 0.
- WB: assert done. At the closing edge, perform writeback per op class; go to IDLE.
- Op classes:
  - Flag-and-write: ADD 00001, AND 00010, SUB 00011, OR 00100, XOR 00101, ADC 00111, SAR 01001, SLR 01010, SAL 01011, SLL 01100, ROL 01101, ROR 01110. R[rd] = res; flags = captured flags.
  - Write-only: MOV 00110, NOT 01000. R[rd] = res; flags unchanged.
  - NOP 00000: no write; flags unchanged.
  - SHOWR 11111: no register write; flags unchanged; show_data = res; show_valid = 1.
  - Any other opcode: illegal = 1; no write; flags unchanged.
- ADC: the sequencer drives the opcode only. The carry input is the ALU's own CF. The result is whatever the ALU returns; the sequencer does not modify it.
- rd == rs is legal; both operands read the same pre-instruction value.

## Timing
- Handshake at edge ending cycle T. READ = T+1, EXEC = T+2, WB = T+3 (done high). instr_ready is high again at T+4 (if !ld_valid).
- Throughput: 1 instruction per 4 cycles.
- Writeback is visible to a READ starting T+4 or later; no hazards are possible.
- ld_valid write in cycle T is visible to an instruction accepted at T+1 or later.
- Reset values (any state, including mid-instruction):
  - state = IDLE; all R[i] = 0; flags = 0; show_data = 0.
  - done, illegal, show_valid, instr_ready = 0 during the reset cycle.
  - alu_op = 0.
- An in-flight instruction is discarded with no writeback. instr_ready rises the cycle after reset deasserts.
- done, illegal and show_valid are high for exactly one cycle per instruction.

## Test plan
- Load R1 = 8'h7F, R2 = 8'h01; ADD rd=1, rs=2 → alu_op = 00001 only in T+2, done at T+3. Expected R1 = 8'h80, flags = {0,0,1,1}.
- Load R3 = 8'h05; SUB rd=3, rs=3 → R3 = 0, ZF = 1; instr_ready low for T+1..T+3 and high at T+4.
- Set flags = 4'b1010 via ADD; then MOV rd=4, rs=3 and NOT rd=5 → R4 and R5 updated, flags remain 4'b1010.
- SHOWR rd=1 after R1 = 8'hA5 → show_valid pulse at T+3 with show_data = 8'hA5; R file unchanged.
- Opcode 10101 → illegal and done pulse together; no register or flag change. Next, ld_valid and instr_valid asserted in the same IDLE cycle → load wins; instruction is accepted the following cycle.
- Assert reset during EXEC of ADD R1,R2 → no writeback; all registers read 0 after reset; flags = 0; instr_ready = 1 the cycle after reset falls.
